// File: rtl/ac97_decimator_if.sv
// Sample bus between the AC97 capture side and the decimator: input strobe/data,
// run/clear controls, and the decimated output strobe feeding the delay stage.
interface ac97_decimator_if #(
  parameter int IN_WIDTH = 16
);
  logic                ready;
  logic [IN_WIDTH-1:0] ac97_sample;
  logic                enable;
  logic                clear_clip;
  logic [11:0]         sample_out;
  logic                sample_ready;
  logic                clipped;

  modport master (
    output ready, ac97_sample, enable, clear_clip,
    input  sample_out, sample_ready, clipped
  );

  modport slave (
    input  ready, ac97_sample, enable, clear_clip,
    output sample_out, sample_ready, clipped
  );
endinterface

// File: rtl/ac97_decimator.sv
// Averages groups of 2^LOG_DECIM AC97 samples, rounds half-up, saturates to
// signed 12 bits and strobes the result two edges after the group completes.
module ac97_decimator #(
  parameter int IN_WIDTH  = 16,
  parameter int LOG_DECIM = 1
) (
  input logic             clock,
  input logic             reset,
  ac97_decimator_if.slave bus
);

  localparam int DECIM = 1 << LOG_DECIM;
  localparam int SHIFT = LOG_DECIM + IN_WIDTH - 12;
  localparam int ACC_W = IN_WIDTH + LOG_DECIM;

  localparam logic [ACC_W:0]       RND  = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [LOG_DECIM-1:0] LAST = LOG_DECIM'(DECIM - 1);

  logic [LOG_DECIM-1:0]    r_count;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_sum;
  logic                    r_v1;
  logic signed [ACC_W:0]   r_rnd;
  logic                    r_v2;
  logic [11:0]             r_out;
  logic                    r_rdy;
  logic                    r_clip;

  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_grp;
  logic signed [12:0]      w_q;
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic [11:0]             w_out;

  assign w_accept = bus.ready & bus.enable;
  assign w_last   = (r_count == LAST);
  assign w_ext    = {{LOG_DECIM{bus.ac97_sample[IN_WIDTH-1]}}, bus.ac97_sample};
  assign w_grp    = (r_count == '0) ? w_ext : r_acc + w_ext;

  // After the shift exactly 13 significant bits remain, so the top two bits
  // disagreeing is the complete out-of-range test.
  assign w_q      = 13'(r_rnd >>> SHIFT);
  assign w_sat_hi = ~w_q[12] &  w_q[11];
  assign w_sat_lo =  w_q[12] & ~w_q[11];
  assign w_out    = w_sat_hi ? 12'h7FF :
                    w_sat_lo ? 12'h800 : w_q[11:0];

  // Group accumulation and stage 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (!bus.enable) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_acc   <= w_grp;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_sum <= w_grp;
          r_v1  <= 1'b1;
        end
      end
    end
  end

  // Stage 2: rounding offset, one bit wider so the add cannot overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rnd <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_rnd <= $signed({r_sum[ACC_W-1], r_sum}) + $signed(RND);
      end
    end
  end

  // Stage 3: narrow, saturate, strobe; saturation beats a coincident clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_rdy  <= 1'b0;
      r_clip <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (r_v2) begin
        r_out <= w_out;
        r_rdy <= 1'b1;
      end
      if (r_v2 && (w_sat_hi || w_sat_lo)) begin
        r_clip <= 1'b1;
      end else if (bus.clear_clip) begin
        r_clip <= 1'b0;
      end
    end
  end

  assign bus.sample_out   = r_out;
  assign bus.sample_ready = r_rdy;
  assign bus.clipped      = r_clip;

endmodule

// File: tb/tb_ac97_decimator.sv
// Self-checking bench for ac97_decimator: directed cases with literal results
// plus randomized traffic compared every cycle against a queue-based model.
module tb_ac97_decimator;

  localparam int IN_WIDTH  = 16;
  localparam int LOG_DECIM = 1;
  localparam int DECIM     = 1 << LOG_DECIM;
  localparam int SHIFT     = LOG_DECIM + IN_WIDTH - 12;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ac97_decimator_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  ac97_decimator #(.IN_WIDTH(IN_WIDTH), .LOG_DECIM(LOG_DECIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a completed group becomes an output two edges after its last accept.
  typedef struct {
    int due;
    int val;
    bit sat;
  } grp_t;

  grp_t pend[$];
  int   edge_n   = 0;
  int   part_sum = 0;
  int   part_n   = 0;
  int   m_out    = 0;
  bit   m_rdy    = 1'b0;
  bit   m_clip   = 1'b0;
  int   m_s;
  int   m_v;
  bit   m_sat;

  function automatic void reduce(input int sum, output int val, output bit sat);
    real avg;
    int  q;
    avg = $floor(real'(sum) / real'(1 << SHIFT) + 0.5);
    q   = int'(avg);
    sat = 1'b0;
    if (q > 2047) begin
      val = 2047;
      sat = 1'b1;
    end else if (q < -2048) begin
      val = -2048;
      sat = 1'b1;
    end else begin
      val = q;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend.delete();
      part_sum = 0;
      part_n   = 0;
      m_out    = 0;
      m_rdy    = 1'b0;
      m_clip   = 1'b0;
    end else begin
      edge_n++;
      m_rdy = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        m_rdy = 1'b1;
        m_out = pend[0].val;
        if (pend[0].sat) m_clip = 1'b1;
        else if (bus.clear_clip) m_clip = 1'b0;
        void'(pend.pop_front());
      end else if (bus.clear_clip) begin
        m_clip = 1'b0;
      end
      if (!bus.enable) begin
        part_sum = 0;
        part_n   = 0;
      end else if (bus.ready) begin
        m_s = int'($signed(bus.ac97_sample));
        part_sum += m_s;
        part_n++;
        if (part_n == DECIM) begin
          reduce(part_sum, m_v, m_sat);
          pend.push_back('{due: edge_n + 2, val: m_v, sat: m_sat});
          part_sum = 0;
          part_n   = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("sample_ready", int'(bus.sample_ready), int'(m_rdy));
      chk("sample_out", int'($signed(bus.sample_out)), m_out);
      chk("clipped", int'(bus.clipped), int'(m_clip));
    end
  end

  int seen[$];
  always @(negedge clock) begin
    if (!reset && bus.sample_ready) seen.push_back(int'($signed(bus.sample_out)));
  end

  task automatic drive(input bit r, input int v, input bit en, input bit clr);
    @(negedge clock);
    bus.ready       = r;
    bus.ac97_sample = IN_WIDTH'(v);
    bus.enable      = en;
    bus.clear_clip  = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic pair(input string name, input int a, input int b, input int gap, input int exp);
    seen.delete();
    drive(1'b1, a, 1'b1, 1'b0);
    idle(gap);
    drive(1'b1, b, 1'b1, 1'b0);
    idle(6);
    #1;
    chk({name, " strobes"}, seen.size(), 1);
    if (seen.size() > 0) chk(name, seen[0], exp);
  endtask

  initial begin
    int val;
    int pick;
    bit clr;
    bus.ready       = 1'b0;
    bus.ac97_sample = '0;
    bus.enable      = 1'b1;
    bus.clear_clip  = 1'b0;
    reset           = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset sample_ready", int'(bus.sample_ready), 0);
    chk("reset sample_out", int'($signed(bus.sample_out)), 0);
    chk("reset clipped", int'(bus.clipped), 0);

    pair("avg 1000/1002", 1000, 1002, 50, 63);
    chk("avg clipped", int'(bus.clipped), 0);

    pair("pos sat", 32767, 32767, 1, 2047);
    chk("pos sat clipped", int'(bus.clipped), 1);
    drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    #1;
    chk("clear_clip", int'(bus.clipped), 0);

    pair("neg limit", -32768, -32768, 1, -2048);
    chk("neg limit clipped", int'(bus.clipped), 0);
    pair("minus16", -16, -16, 1, -1);
    pair("plus16", 16, 16, 1, 1);

    // Enable drop discards the lone 1000
    seen.delete();
    drive(1'b1, 1000, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 64, 1'b1, 1'b0);
    drive(1'b1, 64, 1'b1, 1'b0);
    idle(6);
    #1;
    chk("enable drop strobes", seen.size(), 1);
    if (seen.size() > 0) chk("enable drop value", seen[0], 4);

    seen.delete();
    drive(1'b1, 32, 1'b1, 1'b0);
    drive(1'b1, 32, 1'b1, 1'b0);
    drive(1'b1, 64, 1'b1, 1'b0);
    drive(1'b1, 64, 1'b1, 1'b0);
    idle(6);
    #1;
    chk("b2b strobes", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("b2b first", seen[0], 2);
      chk("b2b second", seen[1], 4);
    end

    // Async reset lands between edges while a group is in flight
    seen.delete();
    drive(1'b1, 1000, 1'b1, 1'b0);
    drive(1'b1, 1002, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async rst sample_ready", int'(bus.sample_ready), 0);
    chk("async rst sample_out", int'($signed(bus.sample_out)), 0);
    chk("async rst clipped", int'(bus.clipped), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(6);
    #1;
    chk("post reset strobes", seen.size(), 0);
    pair("post reset 32/32", 32, 32, 0, 2);

    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 7) == 0);
      pick = $urandom_range(0, 19);
      if (pick == 0) begin
        repeat ($urandom_range(1, 2)) drive(1'b0, int'($urandom_range(0, 65535)), 1'b0, clr);
      end else begin
        pick = $urandom_range(0, 9);
        if (pick == 0) val = 32767;
        else if (pick == 1) val = -32768;
        else val = int'($urandom_range(0, 65535)) - 32768;
        drive(1'b1, val, 1'b1, clr);
        repeat ($urandom_range(0, 3)) drive(1'b0, 0, 1'b1, ($urandom_range(0, 7) == 0));
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ac97_decimator.md
# ac97_decimator

Front-end sample-rate and width converter for the sound-analysis path. Takes signed samples from the AC97 capture interface at 48 kHz, averages each group of 2^LOG_DECIM consecutive samples, then rounds, saturates and narrows the result to a signed 12-bit sample. It emits that sample with a one-cycle strobe at 24 kHz. Its `sample_out`/`sample_ready` pair drives the `incoming_sample`/`ready` inputs of the delay stage directly.

## Interface
- `IN_WIDTH`, 16: width of the incoming AC97 sample (signed). Must be ≥ 12.
- `LOG_DECIM`, 1: log2 of the decimation factor (1 → 48 kHz to 24 kHz). Must be ≥ 1.
- `clock`  input  1: system clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high; clears all state while high.
- `ready`  input  1: one-cycle strobe; `ac97_sample` is valid in the same cycle.
- `ac97_sample`  input  IN_WIDTH: signed two's-complement sample from the AC97 capture.
- `enable`  input  1: high to run. Low discards any partial group and suppresses new accepts.
- `clear_clip`  input  1: synchronous clear of `clipped`.
- `sample_out`  output  12: signed decimated sample. Registered; holds its value between strobes.
- `sample_ready`  output  1: one-cycle strobe; `sample_out` is valid in that cycle.
- `clipped`  output  1: sticky flag; set when any output saturated.

## Operation
- Derived constants:
  - DECIM = 2^LOG_DECIM.
  - SHIFT = LOG_DECIM + IN_WIDTH − 12 (≥ 1).
  - ACC_W = IN_WIDTH + LOG_DECIM.
  - RND = 1 << (SHIFT−1).
- Group counter `count` (LOG_DECIM bits, wraps) and accumulator `acc` (ACC_W bits, signed).
- An accept is `ready && enable` at a clock edge:
  - Sign-extend `ac97_sample` to ACC_W.
  - If `count == 0`, `acc` loads the sample; otherwise `acc` ← `acc` + sample.
  - `count` increments.
- On the accept with `count == DECIM−1`, the group is complete:
  - Stage 1: `sum_r` ← `acc` + sample (or the sample alone when DECIM would be 1). `v1` ← 1. `count` wraps to 0.
  - Stage 2, next edge: `rnd_r` ← `sum_r` + RND, computed at ACC_W+1 bits. `v2` ← `v1`.
  - Stage 3, next edge, if `v2`:
    - q = `rnd_r` >>> SHIFT (arithmetic shift).
    - If q > 2047, `sample_out` ← 2047; if q < −2048, `sample_out` ← −2048. In both cases `clipped` ← 1. Otherwise `sample_out` ← q.
    - `sample_ready` ← 1.
- Rounding is round-half-up, applied as floor after adding RND.
- `sample_ready` is low in every cycle in which stage 3 does not fire.
- The pipeline is fully pipelined: a new group may complete in any cycle while earlier groups are still in flight. There are no stalls and no back-pressure; the downstream stage must accept every strobe.
- `enable` low at an edge:
  - `count` ← 0, discarding any partial group.
  - Stages already holding a valid group complete normally.
  - `ready` is ignored.
- `clipped`:
  - Set at any stage-3 saturation.
  - Cleared when `clear_clip` is high at an edge.
  - If saturation and `clear_clip` coincide, set wins.

## Timing
- Reset values, all zero: `sample_out`, `sample_ready`, `clipped`, `count`, `acc`, `sum_r`, `rnd_r`, `v1`, `v2`.
- Reset asserted mid-group or mid-pipeline discards everything; no strobe follows reset release.
- Latency: the final accept of a group occurs at edge N. `sample_ready` rises after edge N+2 and stays high for exactly one cycle.
- `sample_out` changes only at edges where `sample_ready` is set.
- Minimum `ready` spacing is 1 cycle. At the 48 kHz AC97 rate there are always more than 2 idle cycles between strobes.

## Test plan
Values below use the defaults IN_WIDTH=16 and LOG_DECIM=1, so SHIFT=5 and RND=16.
- Basic average: `ready` with 1000, then 1002, 50 cycles apart → one strobe 2 cycles after the second accept; `sample_out` = 63; `clipped` = 0.
- Positive saturation: 32767, 32767 → (65534+16)>>>5 = 2048 → `sample_out` = 2047; `clipped` = 1. A following `clear_clip` pulse returns `clipped` to 0.
- Negative limits: −32768, −32768 → −2048 with no clip. −16, −16 → −1. 16, 16 → 1.
- Enable drop: accept 1000, drop `enable` for 1 cycle, raise it, accept 64, 64 → exactly one strobe, `sample_out` = 4. No output reflects 1000.
- Back-to-back: `ready` high for 4 consecutive cycles with 32, 32, 64, 64 → strobes on two consecutive-group cycles, values 2 then 4, each one cycle wide.
- Async reset: accept 1000 and 1002, then assert `reset` 1 cycle later, between clock edges → all outputs 0 immediately. No strobe after release. The next pair 32, 32 yields 2.
